aurora_tx_framer: RTL and testbench

Packetizing transmitter on the Aurora user side. Takes a length-announced burst of 32-bit payload words from user logic and emits one framed AXI4-Stream packet per burst into a lane's `s_axi_tx_*` port, in the `user_clk_out` domain. Each frame is a header word, the payload, and an XOR checksum trailer. It respects `tready` backpressure, gates on `channel_up`, and aborts cleanly on link loss. It is the transmit counterpart of the lane's receive-side frame parser.

---
 rtl/aurora_tx_framer_if.sv | 10 +
 rtl/aurora_tx_framer.sv | 81 ++++++++
 tb/tb_aurora_tx_framer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/aurora_tx_framer_if.sv
// aurora_tx_framer_if: AXI4-Stream transmit bus between the framer and an Aurora lane's s_axi_tx port.
interface aurora_tx_framer_if;
    logic [31:0] m_axi_tx_tdata;
    logic [3:0]  m_axi_tx_tkeep;
    logic        m_axi_tx_tlast;
    logic        m_axi_tx_tvalid;
    logic        m_axi_tx_tready;
    modport master (output m_axi_tx_tdata, m_axi_tx_tkeep, m_axi_tx_tlast, m_axi_tx_tvalid, input m_axi_tx_tready);
    modport slave (input m_axi_tx_tdata, m_axi_tx_tkeep, m_axi_tx_tlast, m_axi_tx_tvalid, output m_axi_tx_tready);
endinterface

// File: rtl/aurora_tx_framer.sv
// aurora_tx_framer: frames a length-announced payload burst as header, payload, XOR-checksum trailer.
module aurora_tx_framer #(
    parameter int          MAX_LEN   = 256,
    parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
    input  logic               user_clk_i,
    input  logic               sys_reset_i,
    input  logic               channel_up_i,
    input  logic               frame_start_i,
    input  logic [15:0]        frame_len_i,
    output logic               frame_busy_o,
    input  logic [31:0]        s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    aurora_tx_framer_if.master tx,
    output logic               frame_done_o,
    output logic               frame_err_o,
    output logic [31:0]        frame_cnt_o
);
    typedef enum logic [1:0] {IDLE, HDR, PAY, TRL} state_t;
    localparam logic [15:0] MAX = 16'(MAX_LEN);
    state_t      r_state, w_next;
    logic [15:0] r_rem, r_len;
    logic [31:0] r_chk, r_cnt;
    logic        r_done, r_err;
    logic        w_start, w_legal, w_abort, w_hdr_hs, w_pay_hs, w_trl_hs;
    assign w_start  = r_state == IDLE && frame_start_i && channel_up_i;
    assign w_legal  = frame_len_i != 16'd0 && frame_len_i <= MAX;
    assign w_abort  = r_state != IDLE && !channel_up_i;
    // handshakes are void on the edge the link drops
    assign w_hdr_hs = r_state == HDR && tx.m_axi_tx_tready && channel_up_i;
    assign w_pay_hs = r_state == PAY && s_valid_i && tx.m_axi_tx_tready && channel_up_i;
    assign w_trl_hs = r_state == TRL && tx.m_axi_tx_tready && channel_up_i;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start && w_legal ? HDR : IDLE;
            HDR:     w_next = w_hdr_hs ? PAY : HDR;
            PAY:     w_next = w_pay_hs && r_rem == 16'd1 ? TRL : PAY;
            TRL:     w_next = w_trl_hs ? IDLE : TRL;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end
    always_comb begin
        tx.m_axi_tx_tvalid = r_state == HDR || r_state == TRL || (r_state == PAY && s_valid_i);
        tx.m_axi_tx_tdata  = r_state == HDR ? {SYNC_WORD, r_len} : r_state == TRL ? r_chk : r_state == PAY ? s_data_i : 32'd0;
        tx.m_axi_tx_tlast  = r_state == TRL;
        tx.m_axi_tx_tkeep  = tx.m_axi_tx_tvalid ? 4'hF : 4'h0;
        s_ready_o          = r_state == PAY && tx.m_axi_tx_tready;
        frame_busy_o       = r_state != IDLE;
    end
    always_ff @(posedge user_clk_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_len   <= '0;
            r_chk   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_trl_hs;
            r_err   <= (w_start && !w_legal) || w_abort;
            if (w_start && w_legal) begin
                r_rem <= frame_len_i;
                r_len <= frame_len_i;
            end
            if (w_hdr_hs) r_chk <= {SYNC_WORD, r_len};
            if (w_pay_hs) begin
                r_chk <= r_chk ^ s_data_i;
                r_rem <= r_rem - 16'd1;
            end
            if (w_trl_hs) r_cnt <= r_cnt + 32'd1;
        end
    end
    assign frame_done_o = r_done;
    assign frame_err_o  = r_err;
    assign frame_cnt_o  = r_cnt;
endmodule

// File: tb/tb_aurora_tx_framer.sv
// tb_aurora_tx_framer: directed and randomized frames checked against a beat-list model of header/payload/XOR trailer.
module tb_aurora_tx_framer;
    logic        clk = 1'b0, rst = 1'b1, up = 1'b0, start = 1'b0, sv = 1'b0;
    logic [15:0] len = '0;
    logic [31:0] sd = '0;
    logic        busy, sready, done, err;
    logic [31:0] cnt, exp_cnt = '0;
    logic [31:0] p[$];
    int          tests = 0, fails = 0;
    aurora_tx_framer_if tx();
    aurora_tx_framer #(.MAX_LEN(256), .SYNC_WORD(16'hA5C3)) dut (
        .user_clk_i(clk), .sys_reset_i(rst), .channel_up_i(up), .frame_start_i(start),
        .frame_len_i(len), .frame_busy_o(busy), .s_data_i(sd), .s_valid_i(sv), .s_ready_o(sready),
        .tx(tx), .frame_done_o(done), .frame_err_o(err), .frame_cnt_o(cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {busy, sready, tx.m_axi_tx_tvalid, tx.m_axi_tx_tlast, tx.m_axi_tx_tkeep}, 32'd0);
        chk({tag, "_data"}, tx.m_axi_tx_tdata, 32'd0);
    endtask
    // Called just after a clock edge; returns one cycle after the trailer is accepted.
    task automatic run_frame(input int n, input logic [31:0] pay[$], input int mode);
        logic [31:0] expq[$], obs[$], x, pdata;
        int          lasts = 0, idx = 0, cyc = 0;
        logic        fin = 1'b0, stall = 1'b0, hold = 1'b0;
        x = {16'hA5C3, 16'(n)};
        expq.push_back(x);
        foreach (pay[i]) begin
            expq.push_back(pay[i]);
            x ^= pay[i];
        end
        expq.push_back(x);
        start = 1'b1;
        len = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        chk("hdr_busy", busy, 1);
        chk("hdr_valid", tx.m_axi_tx_tvalid, 1);
        chk("pulse_clear", {done, err}, 0);
        while (!fin && cyc < 30 * (n + 2) + 50) begin
            tx.m_axi_tx_tready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            if (idx < n) begin
                if (!hold) sv = mode == 0 ? 1'b1 : $urandom_range(0, 3) != 0;
                sd = pay[idx];
            end else sv = 1'b0;
            #2;
            if (stall) begin
                chk("hold_valid", tx.m_axi_tx_tvalid, 1);
                chk("hold_data", tx.m_axi_tx_tdata, pdata);
            end
            stall = tx.m_axi_tx_tvalid && !tx.m_axi_tx_tready;
            pdata = tx.m_axi_tx_tdata;
            if (tx.m_axi_tx_tvalid && tx.m_axi_tx_tready) begin
                obs.push_back(tx.m_axi_tx_tdata);
                lasts += int'(tx.m_axi_tx_tlast);
                fin = tx.m_axi_tx_tlast;
            end
            hold = sv && !sready;
            if (sv && sready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        sv = 1'b0;
        chk("timeout", fin, 1);
        if (mode == 0) chk("cycles", cyc, n + 2);
        chk("beats", obs.size(), expq.size());
        for (int i = 0; i < obs.size() && i < expq.size(); i++) chk("beat", obs[i], expq[i]);
        chk("tlast_cnt", lasts, 1);
        exp_cnt++;
        chk("done", done, 1);
        chk("cnt", cnt, exp_cnt);
        chk("dead_cycle", tx.m_axi_tx_tvalid, 0);
        chk("idle", busy, 0);
    endtask
    task automatic reject(input logic [15:0] n);
        start = 1'b1;
        len = n;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rej_err", err, 1);
        chk_quiet("rej");
        @(posedge clk); #1;
        chk("rej_err_clr", err, 0);
        chk("rej_idle", busy, 0);
    endtask
    initial begin
        tx.m_axi_tx_tready = 1'b0;
        #1;
        chk_quiet("reset");
        chk("reset_pulses", {done, err}, 0);
        chk("reset_cnt", cnt, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        up = 1'b1;
        @(posedge clk); #1;
        p = '{32'h11111111, 32'h22222222, 32'h33333333};
        run_frame(3, p, 0);
        run_frame(3, p, 1);
        reject(16'd0);
        reject(16'd257);
        p.delete();
        for (int i = 0; i < 256; i++) p.push_back($urandom);
        run_frame(256, p, 2);
        for (int k = 0; k < 4; k++) begin
            int n;
            n = $urandom_range(1, 20);
            p.delete();
            for (int i = 0; i < n; i++) p.push_back($urandom);
            run_frame(n, p, int'($urandom_range(1, 2)));
        end
        // link drop after two of five payload words
        p = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004, 32'hCAFE0005};
        tx.m_axi_tx_tready = 1'b1;
        start = 1'b1;
        len = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        sv = 1'b1;
        sd = p[0];
        @(posedge clk); #1;
        chk("drop_pay_ready", sready, 1);
        @(posedge clk); #1;
        sd = p[1];
        @(posedge clk); #1;
        sv = 1'b0;
        up = 1'b0;
        chk("drop_no_last", tx.m_axi_tx_tlast, 0);
        @(posedge clk); #1;
        chk("drop_err", err, 1);
        chk_quiet("drop");
        chk("drop_cnt", cnt, exp_cnt);
        start = 1'b1;
        len = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("down_start_err", err, 0);
        chk_quiet("down_start");
        up = 1'b1;
        @(posedge clk); #1;
        // back-to-back frames
        p = '{32'h11111111, 32'h22222222, 32'h33333333};
        run_frame(3, p, 0);
        p = '{32'hDEADBEEF};
        run_frame(1, p, 0);
        // async reset in the middle of the payload
        start = 1'b1;
        len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        sv = 1'b1;
        sd = 32'h0BADF00D;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = '0;
        chk_quiet("arst");
        chk("arst_pulses", {done, err}, 0);
        chk("arst_cnt", cnt, 0);
        @(posedge clk); #1;
        chk("arst_no_err", err, 0);
        rst = 1'b0;
        sv = 1'b0;
        @(posedge clk); #1;
        p = '{$urandom, $urandom};
        run_frame(2, p, 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
